dpram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the dual-port RAM (write port and read port both clocked by clk).
- Shares the single RAM write port between requesters wr0/wr1 and the single RAM read port between rd0/rd1.
- Uses round-robin arbitration per port, a req/ack handshake, and read-data return tagged to the issuing requester.
- Resolves same-cycle write/read address collisions so that write-then-read ordering holds.

---
 rtl/dpram_arbiter.sv | 142 ++++++++++++++
 tb/tb_dpram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin write/read port arbiter for a dual-port RAM.
// Handles req/ack handshakes, registered RAM ports and tagged read return.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   wrX_req/addr/data     write requesters 0/1, wrX_ack combinational grant
//   rdX_req/addr          read requesters 0/1, rdX_ack combinational grant
//   rdX_valid/data        one-cycle read return for requester X
//   ram_wren/wraddr/data  registered RAM write port
//   ram_rdaddr            registered RAM read address
//   ram_rddata            registered RAM read data
module dpram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr0_req,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ack,
    input  logic                  wr1_req,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ack,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_ack,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_ack,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [DATA_WIDTH-1:0] ram_wrdata,
    output logic [ADDR_WIDTH-1:0] ram_rdaddr,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);

    // Pointer value is the id of the requester favoured on a tie.
    logic                  wr_ptr;
    logic                  rd_ptr;

    logic                  wr_sel;
    logic                  wr_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;

    logic                  rd_sel;
    logic                  rd_cand;
    logic                  rd_gnt;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;
    logic                  collide;

    // Read tag pipeline: stage 1 tracks the address register,
    // stage 2 lines up with the RAM output register.
    logic                  tag1_v;
    logic                  tag1_id;
    logic                  tag2_v;
    logic                  tag2_id;

    always_comb begin
        wr_sel = 1'b0;
        if (wr0_req && wr1_req) begin
            wr_sel = wr_ptr;
        end else if (wr1_req) begin
            wr_sel = 1'b1;
        end
        wr_gnt      = (wr0_req | wr1_req) & ~rst;
        wr_addr_sel = wr_sel ? wr1_addr : wr0_addr;
        wr_data_sel = wr_sel ? wr1_data : wr0_data;
    end

    always_comb begin
        rd_sel = 1'b0;
        if (rd0_req && rd1_req) begin
            rd_sel = rd_ptr;
        end else if (rd1_req) begin
            rd_sel = 1'b1;
        end
        rd_cand     = (rd0_req | rd1_req) & ~rst;
        rd_addr_sel = rd_sel ? rd1_addr : rd0_addr;
    end

    // Write-first: a read to the address being written this cycle
    // waits one cycle so it observes the new data from the array.
    always_comb begin
        collide = wr_gnt & rd_cand & (wr_addr_sel == rd_addr_sel);
        rd_gnt  = rd_cand & ~collide;
        wr0_ack = wr_gnt & ~wr_sel;
        wr1_ack = wr_gnt &  wr_sel;
        rd0_ack = rd_gnt & ~rd_sel;
        rd1_ack = rd_gnt &  rd_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_wrdata <= '0;
        end else begin
            ram_wren <= wr_gnt;
            if (wr_gnt) begin
                wr_ptr     <= ~wr_sel;
                ram_wraddr <= wr_addr_sel;
                ram_wrdata <= wr_data_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            ram_rdaddr <= '0;
            tag1_v     <= 1'b0;
            tag1_id    <= 1'b0;
            tag2_v     <= 1'b0;
            tag2_id    <= 1'b0;
        end else begin
            if (rd_gnt) begin
                rd_ptr     <= ~rd_sel;
                ram_rdaddr <= rd_addr_sel;
            end
            tag1_v  <= rd_gnt;
            tag1_id <= rd_sel;
            tag2_v  <= tag1_v;
            tag2_id <= tag1_id;
        end
    end

    always_comb begin
        rd0_valid = tag2_v & ~tag2_id;
        rd1_valid = tag2_v &  tag2_id;
        rd0_data  = ram_rddata;
        rd1_data  = ram_rddata;
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural registered-read RAM.
// Each scenario task drives stimulus and checks its own results.
module tb_dpram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr0_req = 1'b0, wr1_req = 1'b0;
    logic [3:0] wr0_addr = '0, wr1_addr = '0;
    logic [3:0] wr0_data = '0, wr1_data = '0;
    logic       wr0_ack, wr1_ack;
    logic       rd0_req = 1'b0, rd1_req = 1'b0;
    logic [3:0] rd0_addr = '0, rd1_addr = '0;
    logic       rd0_ack, rd1_ack;
    logic       rd0_valid, rd1_valid;
    logic [3:0] rd0_data, rd1_data;
    logic       ram_wren;
    logic [3:0] ram_wraddr, ram_wrdata, ram_rdaddr;
    logic [3:0] ram_rddata;

    logic [3:0] mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Registered-read RAM: old data on same-cycle read/write.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddr] <= ram_wrdata;
        ram_rddata <= mem[ram_rdaddr];
    end

    dpram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack),
        .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack),
        .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
        .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_req = 1'b0; wr1_req = 1'b0;
        rd0_req = 1'b0; rd1_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_wren got=%0b exp=0", ram_wren); end
        total++; if (ram_wraddr !== 4'h0 || ram_wrdata !== 4'h0) begin bad++; $display("FAIL rst_wrport got=%h/%h exp=0/0", ram_wraddr, ram_wrdata); end
        total++; if (ram_rdaddr !== 4'h0) begin bad++; $display("FAIL rst_rdaddr got=%h exp=0", ram_rdaddr); end
        total++; if ({rd0_valid, rd1_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", {rd0_valid, rd1_valid}); end
        wr0_req = 1'b1; wr1_req = 1'b1; rd0_req = 1'b1; rd1_req = 1'b1;
        rd0_addr = 4'h1; rd1_addr = 4'h2; wr0_addr = 4'h3; wr1_addr = 4'h4;
        #1;
        total++; if ({wr0_ack, wr1_ack, rd0_ack, rd1_ack} !== 4'b0000) begin bad++; $display("FAIL rst_acks got=%b exp=0000", {wr0_ack, wr1_ack, rd0_ack, rd1_ack}); end
        cyc();
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_wren_req got=%0b exp=0", ram_wren); end
        idle_inputs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_roundtrip();
        wr0_req = 1'b1; wr0_addr = 4'h3; wr0_data = 4'hA;
        #1;
        total++; if ({wr0_ack, wr1_ack} !== 2'b10) begin bad++; $display("FAIL rt_wack got=%b exp=10", {wr0_ack, wr1_ack}); end
        cyc();
        wr0_req = 1'b0;
        #1;
        total++; if (ram_wren !== 1'b1 || ram_wraddr !== 4'h3 || ram_wrdata !== 4'hA) begin bad++; $display("FAIL rt_wport got=%0b/%h/%h exp=1/3/a", ram_wren, ram_wraddr, ram_wrdata); end
        cyc();
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rt_wren_off got=%0b exp=0", ram_wren); end
        rd1_req = 1'b1; rd1_addr = 4'h3;
        #1;
        total++; if ({rd0_ack, rd1_ack} !== 2'b01) begin bad++; $display("FAIL rt_rack got=%b exp=01", {rd0_ack, rd1_ack}); end
        cyc();
        rd1_req = 1'b0;
        #1;
        total++; if (ram_rdaddr !== 4'h3) begin bad++; $display("FAIL rt_rdaddr got=%h exp=3", ram_rdaddr); end
        total++; if ({rd0_valid, rd1_valid} !== 2'b00) begin bad++; $display("FAIL rt_early got=%b exp=00", {rd0_valid, rd1_valid}); end
        cyc();
        total++; if ({rd0_valid, rd1_valid} !== 2'b01) begin bad++; $display("FAIL rt_valid got=%b exp=01", {rd0_valid, rd1_valid}); end
        total++; if (rd1_data !== 4'hA) begin bad++; $display("FAIL rt_data got=%h exp=a", rd1_data); end
        cyc();
        total++; if ({rd0_valid, rd1_valid} !== 2'b00) begin bad++; $display("FAIL rt_pulse got=%b exp=00", {rd0_valid, rd1_valid}); end
    endtask

    task automatic test_write_contention();
        logic [3:0] ea;
        logic [3:0] ed;
        do_reset();
        wr0_req = 1'b1; wr0_addr = 4'h1; wr0_data = 4'h5;
        wr1_req = 1'b1; wr1_addr = 4'h2; wr1_data = 4'h6;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({wr0_ack, wr1_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL wc_ack%0d got=%b exp=%b", i, {wr0_ack, wr1_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            cyc();
            if (i == 3) idle_inputs();
            ea = (i % 2 == 0) ? 4'h1 : 4'h2;
            ed = (i % 2 == 0) ? 4'h5 : 4'h6;
            total++;
            if (ram_wren !== 1'b1 || ram_wraddr !== ea || ram_wrdata !== ed) begin
                bad++; $display("FAIL wc_port%0d got=%0b/%h/%h exp=1/%h/%h", i, ram_wren, ram_wraddr, ram_wrdata, ea, ed);
            end
        end
        cyc();
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL wc_end got=%0b exp=0", ram_wren); end
    endtask

    task automatic test_read_pipeline();
        int r0q [7] = '{1, 1, 1, 0, 0, 0, 0};
        int r0a [7] = '{0, 2, 2, 0, 0, 0, 0};
        int r1q [7] = '{1, 1, 1, 1, 0, 0, 0};
        int r1a [7] = '{1, 1, 3, 3, 0, 0, 0};
        int ea  [7] = '{2, 1, 2, 1, 0, 0, 0};
        int ev  [7] = '{0, 0, 2, 1, 2, 1, 0};
        int ed  [7] = '{0, 0, 8, 9, 10, 11, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr0_req = 1'b1; wr0_addr = 4'(i); wr0_data = 4'(i) ^ 4'h8;
            cyc();
        end
        idle_inputs();
        cyc();
        cyc();
        for (int k = 0; k < 7; k++) begin
            rd0_req = (r0q[k] != 0); rd0_addr = 4'(r0a[k]);
            rd1_req = (r1q[k] != 0); rd1_addr = 4'(r1a[k]);
            #1;
            total++;
            if ({rd0_ack, rd1_ack} !== 2'(ea[k])) begin
                bad++; $display("FAIL rp_ack%0d got=%b exp=%b", k, {rd0_ack, rd1_ack}, 2'(ea[k]));
            end
            total++;
            if ({rd0_valid, rd1_valid} !== 2'(ev[k])) begin
                bad++; $display("FAIL rp_valid%0d got=%b exp=%b", k, {rd0_valid, rd1_valid}, 2'(ev[k]));
            end
            if (ev[k] != 0) begin
                total++;
                if (ram_rddata !== 4'(ed[k])) begin
                    bad++; $display("FAIL rp_data%0d got=%h exp=%h", k, ram_rddata, 4'(ed[k]));
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        wr1_req = 1'b1; wr1_addr = 4'h7; wr1_data = 4'h3;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        wr0_req = 1'b1; wr0_addr = 4'h7; wr0_data = 4'hC;
        rd0_req = 1'b1; rd0_addr = 4'h7;
        #1;
        total++; if ({wr0_ack, rd0_ack} !== 2'b10) begin bad++; $display("FAIL col_ack got=%b exp=10", {wr0_ack, rd0_ack}); end
        cyc();
        wr0_req = 1'b0;
        #1;
        total++; if (rd0_ack !== 1'b1) begin bad++; $display("FAIL col_defer got=%0b exp=1", rd0_ack); end
        cyc();
        rd0_req = 1'b0;
        #1;
        total++; if (rd0_valid !== 1'b0) begin bad++; $display("FAIL col_early got=%0b exp=0", rd0_valid); end
        cyc();
        total++; if (rd0_valid !== 1'b1 || rd1_valid !== 1'b0) begin bad++; $display("FAIL col_valid got=%0b%0b exp=10", rd0_valid, rd1_valid); end
        total++; if (rd0_data !== 4'hC) begin bad++; $display("FAIL col_data got=%h exp=c", rd0_data); end
        cyc();
    endtask

    task automatic test_no_collision();
        wr1_req = 1'b1; wr1_addr = 4'h4; wr1_data = 4'hD;
        rd1_req = 1'b1; rd1_addr = 4'h5;
        #1;
        total++; if ({wr1_ack, rd1_ack} !== 2'b11) begin bad++; $display("FAIL nc_ack got=%b exp=11", {wr1_ack, rd1_ack}); end
        cyc();
        idle_inputs();
        total++; if (ram_wraddr !== 4'h4 || ram_rdaddr !== 4'h5) begin bad++; $display("FAIL nc_addr got=%h/%h exp=4/5", ram_wraddr, ram_rdaddr); end
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset_midflight();
        rd1_req = 1'b1; rd1_addr = 4'h1;
        #1;
        total++; if (rd1_ack !== 1'b1) begin bad++; $display("FAIL mf_rack1 got=%0b exp=1", rd1_ack); end
        cyc();
        rd1_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 4'h0;
        wr0_req = 1'b1; wr0_addr = 4'h9; wr0_data = 4'h1;
        #1;
        total++; if ({rd0_ack, wr0_ack} !== 2'b11) begin bad++; $display("FAIL mf_ack got=%b exp=11", {rd0_ack, wr0_ack}); end
        cyc();
        idle_inputs();
        rst = 1'b1;
        wr1_req = 1'b1; rd1_req = 1'b1; rd1_addr = 4'h6;
        #1;
        total++; if ({wr1_ack, rd1_ack} !== 2'b00) begin bad++; $display("FAIL mf_rst_ack got=%b exp=00", {wr1_ack, rd1_ack}); end
        cyc();
        idle_inputs();
        rst = 1'b0;
        #1;
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL mf_wren got=%0b exp=0", ram_wren); end
        total++; if ({rd0_valid, rd1_valid} !== 2'b00) begin bad++; $display("FAIL mf_valid0 got=%b exp=00", {rd0_valid, rd1_valid}); end
        cyc();
        total++; if ({rd0_valid, rd1_valid} !== 2'b00) begin bad++; $display("FAIL mf_valid1 got=%b exp=00", {rd0_valid, rd1_valid}); end
        wr0_req = 1'b1; wr0_addr = 4'h2; wr0_data = 4'h6;
        wr1_req = 1'b1; wr1_addr = 4'h3; wr1_data = 4'h7;
        rd0_req = 1'b1; rd0_addr = 4'h0;
        rd1_req = 1'b1; rd1_addr = 4'h1;
        #1;
        total++; if ({wr0_ack, wr1_ack} !== 2'b10) begin bad++; $display("FAIL mf_wr_rr got=%b exp=10", {wr0_ack, wr1_ack}); end
        total++; if ({rd0_ack, rd1_ack} !== 2'b10) begin bad++; $display("FAIL mf_rd_rr got=%b exp=10", {rd0_ack, rd1_ack}); end
        cyc();
        idle_inputs();
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_write_contention();
        test_read_pipeline();
        test_collision();
        test_no_collision();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
